// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux select sequencer: FSM encoding and fixed constants.
package mux_seq_pkg;

    typedef enum logic {
        StStopped = 1'b0,
        StRun     = 1'b1
    } seq_state_e;

    // Highest select value; sel counts 0..SEL_MAX modulo 4.
    localparam logic [1:0] SEL_MAX = 2'd3;

    // Board clock frequency, for choosing period values (e.g. CLK_HZ for 1 Hz).
    localparam int unsigned CLK_HZ = 50_000_000;

endpackage

// File: rtl/rate_divider.sv
// Programmable down-counter that fires once every max(period,1) enabled cycles.
// A start pulse arms the first interval; clear parks the counter at zero.
module rate_divider
    import mux_seq_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 26
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] period,
    output logic                 fire
);

    logic [DIV_WIDTH-1:0] count_q;
    logic [DIV_WIDTH-1:0] reload;

    // period 0 behaves like period 1, so both reload to zero (fire every cycle).
    assign reload = (period == '0) ? '0 : period - DIV_WIDTH'(1);

    assign fire = enable && (count_q == '0);

    // Countdown register; period is only sampled when a new interval begins.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= reload;
        end else if (enable) begin
            if (count_q == '0) begin
                count_q <= reload;
            end else begin
                count_q <= count_q - DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mux_select_sequencer.sv
// Drives the 4-to-1 switch mux: latches the data word and steps the 2-bit select,
// either free-running at a programmable rate or one step per step-button edge.
module mux_select_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 26
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 step,
    input  logic                 dir,
    input  logic                 load,
    input  logic [3:0]           data_in,
    output logic [3:0]           data_out,
    output logic [1:0]           sel,
    output logic                 tick,
    output logic                 wrap,
    output logic                 running
);

    seq_state_e state_q, state_d;
    logic       run_enter;
    logic       step_q;
    logic [1:0] sel_q, sel_d;
    logic [3:0] data_q;
    logic       tick_q, wrap_q, wrap_d;
    logic       div_enable, div_clear, div_fire;
    logic       step_edge, advance;

    // stop pre-empts any divider fire in the cycle it is seen in RUN.
    assign div_enable = (state_q == StRun) && !stop;
    assign div_clear  = (state_q == StRun) && stop;
    assign step_edge  = (state_q == StStopped) && step && !step_q;
    assign advance    = div_fire || step_edge;

    rate_divider #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_rate_divider (
        .clock  (clock),
        .reset  (reset),
        .enable (div_enable),
        .start  (run_enter),
        .clear  (div_clear),
        .period (period),
        .fire   (div_fire)
    );

    // Next-state logic: stop always wins over start.
    always_comb begin
        state_d   = state_q;
        run_enter = 1'b0;
        case (state_q)
            StStopped: begin
                if (start && !stop) begin
                    state_d   = StRun;
                    run_enter = 1'b1;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StStopped;
                end
            end
        endcase
    end

    // Select arithmetic: modular up/down count with a wrap flag on the 3<->0 crossing.
    always_comb begin
        sel_d  = sel_q;
        wrap_d = 1'b0;
        if (advance) begin
            if (dir) begin
                sel_d  = sel_q - 2'd1;
                wrap_d = (sel_q == 2'd0);
            end else begin
                sel_d  = sel_q + 2'd1;
                wrap_d = (sel_q == SEL_MAX);
            end
        end
    end

    // State, select, edge-detect, data latch and registered pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StStopped;
            step_q  <= 1'b0;
            sel_q   <= 2'd0;
            data_q  <= 4'd0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step;
            sel_q   <= sel_d;
            tick_q  <= advance;
            wrap_q  <= wrap_d;
            if (load) begin
                data_q <= data_in;
            end
        end
    end

    assign data_out = data_q;
    assign sel      = sel_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign running  = (state_q == StRun);

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Self-checking bench for mux_select_sequencer: directed scenarios plus a randomized
// run, all compared against a cycles-remaining behavioural model.
module tb_mux_select_sequencer;

    localparam int unsigned DW = 26;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] period = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          step = 1'b0;
    logic          dir = 1'b0;
    logic          load = 1'b0;
    logic [3:0]    data_in = 4'd0;
    logic [3:0]    data_out;
    logic [1:0]    sel;
    logic          tick;
    logic          wrap;
    logic          running;

    int tests = 0;
    int fails = 0;

    // Behavioural model: run flag, cycles left until next tick, select as an integer.
    bit       m_run = 0;
    int       m_left = 0;
    int       m_sel = 0;
    logic [3:0] m_data = 4'd0;
    bit       m_tick = 0;
    bit       m_wrap = 0;
    bit       m_stepprev = 0;

    mux_select_sequencer #(
        .DIV_WIDTH(DW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .period   (period),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .dir      (dir),
        .load     (load),
        .data_in  (data_in),
        .data_out (data_out),
        .sel      (sel),
        .tick     (tick),
        .wrap     (wrap),
        .running  (running)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic model_edge();
        int eff;
        bit adv;
        eff = (period == 0) ? 1 : int'(period);
        adv = 0;
        if (reset) begin
            m_run = 0; m_left = 0; m_sel = 0; m_data = 4'd0;
            m_tick = 0; m_wrap = 0; m_stepprev = 0;
        end else begin
            if (m_run) begin
                if (stop) begin
                    m_run = 0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        adv = 1;
                        m_left = eff;
                    end
                end
            end else begin
                if (step && !m_stepprev) adv = 1;
                if (start && !stop) begin
                    m_run = 1;
                    m_left = eff;
                end
            end
            m_stepprev = step;
            if (load) m_data = data_in;
            m_wrap = adv && (dir ? (m_sel == 0) : (m_sel == 3));
            if (adv) m_sel = dir ? (m_sel + 3) % 4 : (m_sel + 1) % 4;
            m_tick = adv;
        end
    endtask

    function automatic logic [8:0] model_vec();
        logic [1:0] s;
        s = 2'(m_sel);
        return {m_data, s, m_tick, m_wrap, m_run};
    endfunction

    // One clock edge; the model sees the same inputs the DUT sampled.
    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        tests++;
        if ({data_out, sel, tick, wrap, running} !== 9'd0) begin
            fails++;
            $display("FAIL reset_state: got %b required %b", {data_out, sel, tick, wrap, running}, 9'd0);
        end
        reset = 1'b0;
        load = 1'b1;
        data_in = 4'b1010;
        cycle();
        load = 1'b0;
        data_in = 4'd0;
        tests++;
        if ({data_out, sel, tick, wrap, running} !== {4'b1010, 2'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL load_1010: got %b required %b", {data_out, sel, tick, wrap, running},
                     {4'b1010, 5'd0});
        end
    endtask

    task automatic test_run_up();
        logic [1:0] esel;
        period = 26'd4;
        dir = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        tests++;
        if (running !== 1'b1) begin
            fails++;
            $display("FAIL run_up_enter: running got %b required 1", running);
        end
        for (int i = 1; i <= 16; i++) begin
            cycle();
            esel = 2'((i / 4) % 4);
            tests++;
            if ({sel, tick, wrap} !== {esel, (i % 4) == 0, i == 16}) begin
                fails++;
                $display("FAIL run_up cycle %0d: sel/tick/wrap got %b required %b", i,
                         {sel, tick, wrap}, {esel, (i % 4) == 0, i == 16});
            end
            tests++;
            if ({data_out, sel, tick, wrap, running} !== model_vec()) begin
                fails++;
                $display("FAIL run_up_model cycle %0d: got %b required %b", i,
                         {data_out, sel, tick, wrap, running}, model_vec());
            end
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_run_fast_down();
        logic [1:0] esel;
        period = 26'd0;
        dir = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            esel = 2'((4 - (i % 4)) % 4);
            tests++;
            if ({sel, tick, wrap} !== {esel, 1'b1, (i == 1) || (i == 5)}) begin
                fails++;
                $display("FAIL fast_down cycle %0d: sel/tick/wrap got %b required %b", i,
                         {sel, tick, wrap}, {esel, 1'b1, (i == 1) || (i == 5)});
            end
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        tests++;
        if ({sel, tick, running} !== {2'd3, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL fast_down_stop: sel/tick/running got %b required %b",
                     {sel, tick, running}, {2'd3, 2'b00});
        end
    endtask

    task automatic test_step();
        int nticks;
        int pattern [8] = '{1, 1, 1, 1, 1, 0, 0, 1};
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        dir = 1'b0;
        nticks = 0;
        for (int i = 0; i < 9; i++) begin
            step = (i < 8) ? pattern[i][0] : 1'b0;
            cycle();
            if (tick === 1'b1) nticks++;
            tests++;
            if ({data_out, sel, tick, wrap, running} !== model_vec()) begin
                fails++;
                $display("FAIL step_model cycle %0d: got %b required %b", i,
                         {data_out, sel, tick, wrap, running}, model_vec());
            end
        end
        step = 1'b0;
        tests++;
        if (nticks !== 2 || sel !== 2'd2) begin
            fails++;
            $display("FAIL step_count: ticks %0d sel %0d required ticks 2 sel 2", nticks, sel);
        end
    endtask

    task automatic test_start_stop();
        start = 1'b1;
        stop = 1'b1;
        cycle();
        start = 1'b0;
        stop = 1'b0;
        tests++;
        if (running !== 1'b0) begin
            fails++;
            $display("FAIL start_stop_together: running got %b required 0", running);
        end
        for (int i = 0; i < 4 && sel !== 2'd2; i++) begin
            step = 1'b1;
            cycle();
            step = 1'b0;
            cycle();
        end
        period = 26'd6;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            tests++;
            if ({sel, tick, running} !== {2'd2, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL stop_hold cycle %0d: sel/tick/running got %b required %b", i,
                         {sel, tick, running}, {2'd2, 2'b00});
            end
        end
    endtask

    task automatic test_reset_mid_run();
        load = 1'b1;
        data_in = 4'b0110;
        cycle();
        load = 1'b0;
        period = 26'd3;
        dir = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        tests++;
        if ({tick, running, data_out} !== {1'b0, 1'b1, 4'b0110}) begin
            fails++;
            $display("FAIL pre_reset_run: tick/running/data got %b required %b",
                     {tick, running, data_out}, {2'b01, 4'b0110});
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        tests++;
        if ({data_out, sel, tick, wrap, running} !== 9'd0) begin
            fails++;
            $display("FAIL reset_mid_run: got %b required %b",
                     {data_out, sel, tick, wrap, running}, 9'd0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            start   = ($urandom_range(0, 9) == 0);
            stop    = ($urandom_range(0, 24) == 0);
            step    = ($urandom_range(0, 2) == 0);
            dir     = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            load    = ($urandom_range(0, 4) == 0);
            data_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) period = DW'($urandom_range(0, 5));
            cycle();
            tests++;
            if ({data_out, sel, tick, wrap, running} !== model_vec()) begin
                fails++;
                $display("FAIL random cycle %0d: got %b required %b", i,
                         {data_out, sel, tick, wrap, running}, model_vec());
            end
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; load = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_run_up();
        test_run_fast_down();
        test_step();
        test_start_stop();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
